// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: SLL/SRL/SRA/ROR shifter, coarse (multiple-of-4) shift in stage A, fine (0..3) in stage B.
// Latency 2 cycles, throughput 1/cycle; in_ready is combinational from out_ready, so there is no bubble.
// Macro SHIFTER_ROTATE_EN enables op 11 (rotate right); without it op 11 yields zero and no rotate muxes exist.

// pipelined_barrel_shifter_level: one mux rank of the shift network, shifting by the constant SH when sel is set.
// Latency 0 (combinational).
// No backpressure; pure datapath.
module pipelined_barrel_shifter_level #(
  parameter int N  = 32,
  parameter int SH = 1
) (
  input  logic         sel,
  input  logic [1:0]   op,
  input  logic         sign,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  always_comb begin
    q = d;
    if (sel) begin
      case (op)
        OP_SLL:  q = {d[N-1-SH:0], {SH{1'b0}}};
        OP_SRL:  q = {{SH{1'b0}}, d[N-1:SH]};
        // Fill comes from the original operand MSB, not this rank's input.
        OP_SRA:  q = {{SH{sign}}, d[N-1:SH]};
        default: begin
`ifdef SHIFTER_ROTATE_EN
          q = {d[SH-1:0], d[N-1:SH]};
`else
          q = d;
`endif
        end
      endcase
    end
  end
endmodule

// pipelined_barrel_shifter: two register slots (A: coarse result, B: final result), each with its own valid.
// Latency 2 cycles from input transfer to out_valid.
// B advances when empty or drained; A advances when empty or B advances; in_ready = A advances.
module pipelined_barrel_shifter #(
  parameter  int N = 32,
  localparam int S = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [S-1:0] in_shamt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_zero
);
  localparam int CL = S - 2;

  logic         a_vld;
  logic [N-1:0] a_dat;
  logic [1:0]   a_op;
  logic [1:0]   a_fine;
  logic         a_sign;
  logic         b_vld;
  logic [N-1:0] b_dat;
  logic         a_adv;
  logic         b_adv;

  logic [N-1:0] coarse [CL+1];
  logic [N-1:0] fine   [3];

  assign b_adv    = !b_vld || out_ready;
  assign a_adv    = !a_vld || b_adv;
  assign in_ready = a_adv;

`ifdef SHIFTER_ROTATE_EN
  assign coarse[0] = in_data;
`else
  // Zeroing the operand up front lets op 11 fall through every rank unchanged.
  assign coarse[0] = (in_op == 2'b11) ? '0 : in_data;
`endif

  for (genvar k = 0; k < CL; k++) begin : g_coarse
    pipelined_barrel_shifter_level #(.N(N), .SH(4 << k)) u_lvl (
      .sel  (in_shamt[k+2]),
      .op   (in_op),
      .sign (in_data[N-1]),
      .d    (coarse[k]),
      .q    (coarse[k+1])
    );
  end

  assign fine[0] = a_dat;

  for (genvar k = 0; k < 2; k++) begin : g_fine
    pipelined_barrel_shifter_level #(.N(N), .SH(1 << k)) u_lvl (
      .sel  (a_fine[k]),
      .op   (a_op),
      .sign (a_sign),
      .d    (fine[k]),
      .q    (fine[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_vld  <= 1'b0;
      a_dat  <= '0;
      a_op   <= '0;
      a_fine <= '0;
      a_sign <= 1'b0;
      b_vld  <= 1'b0;
      b_dat  <= '0;
    end else begin
      if (a_adv) begin
        a_vld <= in_valid;
        if (in_valid) begin
          a_dat  <= coarse[CL];
          a_op   <= in_op;
          a_fine <= in_shamt[1:0];
          a_sign <= in_data[N-1];
        end
      end
      if (b_adv) begin
        b_vld <= a_vld;
        if (a_vld) begin
          b_dat <= fine[2];
        end
      end
    end
  end

  assign out_valid = b_vld;
  assign out_data  = b_dat;
  assign out_zero  = b_vld && (b_dat == '0);
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: directed cases, backpressure, mid-stream reset and a random sweep
// against an arithmetic reference model; rotate expectations follow SHIFTER_ROTATE_EN.
module tb_pipelined_barrel_shifter;
  localparam int N = 32;
  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero;

  int checks = 0;
  int errors = 0;
  int sent = 0;
  int drained = 0;
  logic [N-1:0] exp_q[$];
  logic         stalled = 1'b0;
  logic [N-1:0] held_data;
  logic         held_zero;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int sh, input logic [1:0] op);
    logic [N-1:0] r;
    case (op)
      2'b00:   r = d << sh;
      2'b01:   r = d >> sh;
      2'b10:   r = $signed(d) >>> sh;
      default: begin
`ifdef SHIFTER_ROTATE_EN
        logic [2*N-1:0] dd;
        dd = {d, d} >> sh;
        r  = dd[N-1:0];
`else
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  // One clock: inputs were set at the preceding negedge; sample just before the rising edge.
  task automatic cycle();
    logic [N-1:0] e;
    #2;
    if (stalled && !rst) begin
      chk("hold_data", out_data, held_data);
      chk1("hold_zero", out_zero, held_zero);
    end
    if (!rst && out_valid && out_ready) begin
      chk1("out_has_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e);
        chk1("out_zero", out_zero, e == '0);
        drained++;
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(ref_shift(in_data, int'(in_shamt), in_op));
      sent++;
    end
    stalled   = !rst && out_valid && !out_ready;
    held_data = out_data;
    held_zero = out_zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic [N-1:0] d, input logic [S-1:0] sh,
                          input logic [1:0] op, input logic [N-1:0] exp);
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    cycle();
    in_valid = 1'b0;
    chk1({tag, "_lat1_valid"}, out_valid, 1'b0);
    cycle();
    chk1({tag, "_lat2_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk1({tag, "_zero"}, out_zero, exp == '0);
    cycle();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shamt  = '0;
    in_op     = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk1("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_data", out_data, 32'h0);
    chk1("reset_out_zero", out_zero, 1'b0);
    @(negedge clk);

    directed("sra", 32'h8000_0010, 5'd4, 2'b10, 32'hF800_0001);
    directed("sll", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    directed("srl_zero", 32'h0000_0001, 5'd1, 2'b01, 32'h0000_0000);
    directed("sra_sh0", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF);
    directed("sra_sh31", 32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
`ifdef SHIFTER_ROTATE_EN
    directed("ror", 32'h0000_00F1, 5'd4, 2'b11, 32'h1000_000F);
`else
    directed("ror", 32'h0000_00F1, 5'd4, 2'b11, 32'h0000_0000);
`endif
    chk1("directed_queue_empty", exp_q.size() == 0, 1'b1);

    // Backpressure: three SRL offers with out_ready low; third must be refused.
    out_ready = 1'b0;
    drained   = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hF000_0000 >> i;
      in_shamt = 5'(i + 3);
      in_op    = 2'b01;
      #1;
      chk1("bp_in_ready", in_ready, i < 2);
      cycle();
    end
    #1;
    chk1("bp_in_ready_held", in_ready, 1'b0);
    cycle();
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) cycle();
    chk("bp_drained", 32'(drained), 32'd3);
    chk1("bp_queue_empty", exp_q.size() == 0, 1'b1);

    // Reset with both slots occupied discards them.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5678 + 32'(i);
      in_shamt = 5'd2;
      in_op    = 2'b00;
      cycle();
    end
    in_valid = 1'b0;
    chk1("mid_full_valid", out_valid, 1'b1);
    chk1("mid_full_in_ready", in_ready, 1'b0);
    rst = 1'b1;
    cycle();
    chk1("mid_reset_out_valid", out_valid, 1'b0);
    chk("mid_reset_out_data", out_data, 32'h0);
    exp_q.delete();
    rst       = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    chk1("mid_reset_no_ghost", out_valid, 1'b0);
    chk1("mid_reset_in_ready", in_ready, 1'b1);

    // Random sweep with random backpressure.
    sent    = 0;
    drained = 0;
    for (int c = 0; c < 20000 && sent < 1024; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      case ($urandom_range(0, 3))
        0:       in_data = 32'($urandom_range(0, 15));
        1:       in_data = 32'h8000_0000 | $urandom;
        default: in_data = $urandom;
      endcase
      in_shamt  = 5'($urandom_range(0, 31));
      in_op     = 2'($urandom_range(0, 3));
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) cycle();
    chk("rand_sent", 32'(sent), 32'd1024);
    chk("rand_drained", 32'(drained), 32'd1024);
    chk1("rand_queue_empty", exp_q.size() == 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
